// File: rtl/y86_wb_regfile.sv
`default_nettype none
// =============================================================================
// Module  : y86_wb_regfile
// Brief   : Y86-64 writeback stage: destination decode, register file with two
//           bypassable read ports, sticky halt and retired-instruction counter.
// Revision: 1.0
// =============================================================================
module y86_wb_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int CNT_W  = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_valid,
  input  logic [1:0]        w_stat,
  input  logic [3:0]        w_icode,
  input  logic [3:0]        w_rA,
  input  logic [3:0]        w_rB,
  input  logic              w_cnd,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rdA,
  output logic [DATA_W-1:0] rdB,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o
);

  localparam logic [1:0] c_stat_aok = 2'd0;
  localparam logic [3:0] c_rnone    = 4'hF;
  localparam logic [3:0] c_rsp      = 4'd4;
  localparam logic [3:0] c_i_cmov   = 4'd2;
  localparam logic [3:0] c_i_irmov  = 4'd3;
  localparam logic [3:0] c_i_mrmov  = 4'd5;
  localparam logic [3:0] c_i_op     = 4'd6;
  localparam logic [3:0] c_i_call   = 4'd8;
  localparam logic [3:0] c_i_ret    = 4'd9;
  localparam logic [3:0] c_i_push   = 4'd10;
  localparam logic [3:0] c_i_pop    = 4'd11;
  localparam logic [4:0] c_nreg     = 5'(NREG);

  function automatic logic f_in_range(input logic [3:0] r);
    return ({1'b0, r} < c_nreg);
  endfunction

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_halted;
  logic [CNT_W-1:0]  r_retired;

  logic              w_commit;
  logic              w_fault;
  logic [3:0]        w_dste_raw;
  logic [3:0]        w_dstm_raw;
  logic [3:0]        w_dste;
  logic [3:0]        w_dstm;
  logic [NREG-1:0]   w_we_e;
  logic [NREG-1:0]   w_we_m;

  // rst_n gates commit so a write presented during reset neither lands nor bypasses
  assign w_commit = rst_n && w_valid && !r_halted && (w_stat == c_stat_aok);
  assign w_fault  = w_valid && !r_halted && (w_stat != c_stat_aok);

  always_comb begin
    w_dste_raw = c_rnone;
    w_dstm_raw = c_rnone;
    case (w_icode)
      c_i_cmov: begin
        if (w_cnd) w_dste_raw = w_rB;
      end
      c_i_irmov, c_i_op: begin
        w_dste_raw = w_rB;
      end
      c_i_call, c_i_ret, c_i_push: begin
        w_dste_raw = c_rsp;
      end
      c_i_pop: begin
        w_dste_raw = c_rsp;
        w_dstm_raw = w_rA;
      end
      c_i_mrmov: begin
        w_dstm_raw = w_rA;
      end
      default: begin
      end
    endcase
  end

  assign w_dste = (w_commit && f_in_range(w_dste_raw)) ? w_dste_raw : c_rnone;
  assign w_dstm = (w_commit && f_in_range(w_dstm_raw)) ? w_dstm_raw : c_rnone;
  assign dstE_o = w_dste;
  assign dstM_o = w_dstm;

  always_comb begin
    w_we_e = '0;
    w_we_m = '0;
    for (int i = 0; i < NREG; i++) begin
      w_we_e[i] = (w_dste == 4'(i));
      w_we_m[i] = (w_dstm == 4'(i));
    end
  end

  // valM is checked first so popq %rsp leaves %rsp = valM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_we_m[i])      r_regs[i] <= w_valM;
        else if (w_we_e[i]) r_regs[i] <= w_valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_fault)  r_halted  <= 1'b1;
      if (w_commit) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign halted  = r_halted;
  assign retired = r_retired;

  logic [3:0]        w_src [2];
  logic [DATA_W-1:0] w_rd  [2];

  assign w_src[0] = srcA;
  assign w_src[1] = srcB;
  assign rdA      = w_rd[0];
  assign rdB      = w_rd[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              w_in;
    logic [DATA_W-1:0] w_arr;

    assign w_in  = f_in_range(w_src[p]);
    assign w_arr = w_in ? r_regs[w_src[p]] : '0;

    if (BYPASS != 0) begin : g_bypass
      // w_dstm/w_dste are either in range or RNONE, so an in-range src never matches "none"
      assign w_rd[p] = (w_in && (w_src[p] == w_dstm)) ? w_valM :
                       (w_in && (w_src[p] == w_dste)) ? w_valE : w_arr;
    end else begin : g_no_bypass
      assign w_rd[p] = w_arr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_wb_regfile.sv
`default_nettype none
// =============================================================================
// Module  : tb_y86_wb_regfile
// Brief   : Directed vector bench for y86_wb_regfile (bypassed and unbypassed).
// Revision: 1.0
// =============================================================================
module tb_y86_wb_regfile;

  typedef struct packed {
    logic        valid;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } in_t;

  typedef struct {
    in_t         in;
    logic [63:0] rda;
    logic [63:0] rdb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [31:0] ret;
    logic        halt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  in_t  a;
  in_t  b;

  logic [63:0] rda_a, rdb_a, rda_b, rdb_b;
  logic        halt_a, halt_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;
  logic [3:0]  dste_a, dstm_a, dste_b, dstm_b;

  int n_vec = 0;
  int n_err = 0;
  vec_t tv[$];

  y86_wb_regfile dut_a (
    .clk(clk), .rst_n(rst_n),
    .w_valid(a.valid), .w_stat(a.stat), .w_icode(a.icode),
    .w_rA(a.ra), .w_rB(a.rb), .w_cnd(a.cnd),
    .w_valE(a.vale), .w_valM(a.valm),
    .srcA(a.srca), .srcB(a.srcb),
    .rdA(rda_a), .rdB(rdb_a),
    .halted(halt_a), .retired(ret_a),
    .dstE_o(dste_a), .dstM_o(dstm_a)
  );

  y86_wb_regfile #(.DATA_W(64), .NREG(12), .CNT_W(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .w_valid(b.valid), .w_stat(b.stat), .w_icode(b.icode),
    .w_rA(b.ra), .w_rB(b.rb), .w_cnd(b.cnd),
    .w_valE(b.vale), .w_valM(b.valm),
    .srcA(b.srca), .srcB(b.srcb),
    .rdA(rda_b), .rdB(rdb_b),
    .halted(halt_b), .retired(ret_b),
    .dstE_o(dste_b), .dstM_o(dstm_b)
  );

  function automatic in_t mi(input logic v, input logic [1:0] st, input logic [3:0] ic,
                             input logic [3:0] ra, input logic [3:0] rb, input logic cnd,
                             input logic [63:0] ve, input logic [63:0] vm,
                             input logic [3:0] sa, input logic [3:0] sb);
    in_t x;
    x.valid = v; x.stat = st; x.icode = ic; x.ra = ra; x.rb = rb; x.cnd = cnd;
    x.vale = ve; x.valm = vm; x.srca = sa; x.srcb = sb;
    return x;
  endfunction

  function automatic vec_t mk(input in_t x, input logic [63:0] rda, input logic [63:0] rdb,
                              input logic [3:0] dste, input logic [3:0] dstm,
                              input logic [31:0] ret, input logic halt);
    vec_t t;
    t.in = x; t.rda = rda; t.rdb = rdb; t.dste = dste; t.dstm = dstm;
    t.ret = ret; t.halt = halt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [63:0] rda, input logic [63:0] rdb,
                       input logic [3:0] dste, input logic [3:0] dstm,
                       input logic [31:0] ret, input logic halt);
    n_vec++;
    chk({tag, ".rdA"}, rda_a, rda);
    chk({tag, ".rdB"}, rdb_a, rdb);
    chk({tag, ".dstE"}, 64'(dste_a), 64'(dste));
    chk({tag, ".dstM"}, 64'(dstm_a), 64'(dstm));
    chk({tag, ".retired"}, 64'(ret_a), 64'(ret));
    chk({tag, ".halted"}, 64'(halt_a), 64'(halt));
  endtask

  task automatic chk_b(input string tag, input logic [63:0] rda, input logic [63:0] rdb,
                       input logic [3:0] dste, input logic [3:0] dstm,
                       input logic [3:0] ret);
    n_vec++;
    chk({tag, ".rdA"}, rda_b, rda);
    chk({tag, ".rdB"}, rdb_b, rdb);
    chk({tag, ".dstE"}, 64'(dste_b), 64'(dste));
    chk({tag, ".dstM"}, 64'(dstm_b), 64'(dstm));
    chk({tag, ".retired"}, 64'(ret_b), 64'(ret));
    chk({tag, ".halted"}, 64'(halt_b), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    a = mi(0, 0, 0, 15, 15, 0, 0, 0, 0, 0);
    b = mi(0, 0, 0, 15, 15, 0, 0, 0, 0, 0);

    // inputs, then rdA, rdB, dstE, dstM, retired, halted sampled before the edge
    tv.push_back(mk(mi(0,0, 0,15,15,0, 64'd0,     64'd0,    2, 0), 64'd0,     64'd0,     15,15, 0,0));
    tv.push_back(mk(mi(1,0, 3,15, 2,0, 64'd57,    64'd0,    2, 3), 64'd57,    64'd0,      2,15, 0,0));
    tv.push_back(mk(mi(0,0, 0,15,15,0, 64'd0,     64'd0,    2, 1), 64'd57,    64'd0,     15,15, 1,0));
    tv.push_back(mk(mi(1,0, 2,15,10,0, 64'd51,    64'd0,   10, 2), 64'd0,     64'd57,    15,15, 1,0));
    tv.push_back(mk(mi(1,0, 2,15,10,1, 64'd51,    64'd0,   10, 5), 64'd51,    64'd0,     10,15, 2,0));
    tv.push_back(mk(mi(1,0,11, 3,15,0, 64'd50,    64'd40,   4, 3), 64'd50,    64'd40,     4, 3, 3,0));
    tv.push_back(mk(mi(0,0, 0,15,15,0, 64'd0,     64'd0,    4, 3), 64'd50,    64'd40,    15,15, 4,0));
    tv.push_back(mk(mi(1,0,11, 4,15,0, 64'd50,    64'd40,   4,10), 64'd40,    64'd51,     4, 4, 4,0));
    tv.push_back(mk(mi(0,0, 0,15,15,0, 64'd0,     64'd0,    4,10), 64'd40,    64'd51,    15,15, 5,0));
    tv.push_back(mk(mi(1,0, 5, 9,15,0, 64'd99,    64'd49,   9, 9), 64'd49,    64'd49,    15, 9, 5,0));
    tv.push_back(mk(mi(1,0, 6, 1, 9,0, 64'd77,    64'd5,    9, 6), 64'd77,    64'd0,      9,15, 6,0));
    tv.push_back(mk(mi(1,0, 8,15,15,0, 64'h1000,  64'd0,    4, 9), 64'h1000,  64'd77,     4,15, 7,0));
    tv.push_back(mk(mi(1,0, 1,15,15,0, 64'd5,     64'd0,    4,15), 64'h1000,  64'd0,     15,15, 8,0));
    tv.push_back(mk(mi(1,0, 4, 1, 2,0, 64'd3,     64'd0,    2, 1), 64'd57,    64'd0,     15,15, 9,0));
    tv.push_back(mk(mi(1,0, 9,15,15,0, 64'h2000,  64'h33,   4, 0), 64'h2000,  64'd0,      4,15,10,0));
    tv.push_back(mk(mi(1,0,10, 3,15,0, 64'hff8,   64'd0,    4, 3), 64'hff8,   64'd40,     4,15,11,0));
    tv.push_back(mk(mi(1,0, 7,15,15,0, 64'd1,     64'd0,    4,10), 64'hff8,   64'd51,    15,15,12,0));
    tv.push_back(mk(mi(0,0, 3,15, 7,0, 64'd123,   64'd0,    7, 4), 64'd0,     64'hff8,   15,15,13,0));
    tv.push_back(mk(mi(1,1, 3,15, 1,0, 64'd7,     64'd0,    1, 7), 64'd0,     64'd0,     15,15,13,0));
    tv.push_back(mk(mi(1,0, 3,15, 1,0, 64'd7,     64'd0,    1, 2), 64'd0,     64'd57,    15,15,13,1));
    tv.push_back(mk(mi(0,0, 0,15,15,0, 64'd0,     64'd0,    1, 2), 64'd0,     64'd57,    15,15,13,1));

    repeat (2) @(negedge clk);
    #1;
    chk_a("reset_a", 0, 0, 15, 15, 0, 0);
    chk_b("reset_b", 0, 0, 15, 15, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      a = tv[i].in;
      #1;
      chk_a($sformatf("vec%0d", i), tv[i].rda, tv[i].rdb, tv[i].dste, tv[i].dstm,
            tv[i].ret, tv[i].halt);
    end

    // reset mid-sequence with a write pending: reset wins, state clears
    @(negedge clk);
    rst_n = 1'b0;
    a = mi(1, 0, 3, 15, 2, 0, 64'd99, 64'd0, 2, 10);
    #1;
    chk_a("rst_during_write", 0, 0, 15, 15, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a = mi(0, 0, 0, 15, 15, 0, 0, 0, 2, 10);
    #1;
    chk_a("after_rst", 0, 0, 15, 15, 0, 0);
    @(negedge clk);
    a = mi(1, 0, 3, 15, 1, 0, 64'd7, 64'd0, 1, 2);
    #1;
    chk_a("irmov_after_rst", 64'd7, 0, 1, 15, 0, 0);
    @(negedge clk);
    a = mi(0, 0, 0, 15, 15, 0, 0, 0, 1, 2);
    #1;
    chk_a("irmov_after_rst_q", 64'd7, 0, 15, 15, 1, 0);

    // no-bypass instance, NREG=12, CNT_W=4
    @(negedge clk);
    b = mi(1, 0, 5, 9, 15, 0, 64'd0, 64'd49, 9, 12);
    #1;
    chk_b("nb_mrmov_pre", 0, 0, 15, 9, 0);
    @(negedge clk);
    b = mi(0, 0, 0, 15, 15, 0, 0, 0, 9, 12);
    #1;
    chk_b("nb_mrmov_post", 64'd49, 0, 15, 15, 1);
    @(negedge clk);
    b = mi(1, 0, 5, 9, 15, 0, 64'd0, 64'd55, 9, 0);
    #1;
    chk_b("nb_old_value", 64'd49, 0, 15, 9, 1);
    @(negedge clk);
    b = mi(1, 0, 3, 15, 13, 0, 64'd5, 64'd0, 13, 9);
    #1;
    chk_b("nb_dst_oor", 0, 64'd55, 15, 15, 2);
    @(negedge clk);
    b = mi(1, 0, 11, 14, 15, 0, 64'd66, 64'd77, 4, 14);
    #1;
    chk_b("nb_pop_oor", 0, 0, 4, 15, 3);
    @(negedge clk);
    b = mi(0, 0, 0, 15, 15, 0, 0, 0, 4, 14);
    #1;
    chk_b("nb_pop_post", 64'd66, 0, 15, 15, 4);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      b = mi(1, 0, 1, 15, 15, 0, 0, 0, 4, 13);
    end
    @(negedge clk);
    b = mi(0, 0, 0, 15, 15, 0, 0, 0, 4, 13);
    #1;
    chk_b("nb_count15", 64'd66, 0, 15, 15, 15);
    @(negedge clk);
    b = mi(1, 0, 1, 15, 15, 0, 0, 0, 4, 13);
    @(negedge clk);
    b = mi(0, 0, 0, 15, 15, 0, 0, 0, 4, 13);
    #1;
    chk_b("nb_wrap", 64'd66, 0, 15, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_wb_regfile.md
# y86_wb_regfile

Parametrised writeback stage and register file for the Y86-64 core, usable by both SEQ and the pipelined design. It takes one retiring instruction per cycle, decodes its destinations (dstE, dstM) from icode/rA/rB/cnd, and commits valE/valM into an internal register array. It also provides two read ports with optional same-cycle write bypass, a sticky halt on non-AOK status, and a retired-instruction counter.

## Interface
- DATA_W, 64, register width
- NREG, 15, number of architectural registers; index 15 (RNONE) is never stored
- CNT_W, 32, retired-instruction counter width
- BYPASS, 1, 1 = read ports forward same-cycle writes; 0 = read ports show array contents only

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  writeback slot holds a real instruction this cycle
- w_stat  in  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- w_icode  in  4  instruction code
- w_rA, w_rB  in  4 each  register specifiers
- w_cnd  in  1  condition result (used by cmovXX only)
- w_valE, w_valM  in  DATA_W each  ALU result and memory result
- srcA, srcB  in  4 each  read addresses
- rdA, rdB  out  DATA_W each  read data (0 when address ≥ NREG)
- halted  out  1  sticky; set by a valid non-AOK instruction
- retired  out  CNT_W  count of committed valid AOK instructions
- dstE_o, dstM_o  out  4 each  decoded destinations for this cycle (15 = none); used by hazard logic

## Operation
- Decode (combinational; forced to 15 unless w_valid && !halted && w_stat==AOK):
  - icode 2 (cmovXX): dstE = w_cnd ? rB : 15
  - icode 3 (irmovq), 6 (OPq): dstE = rB
  - icode 8, 9, 10 (call, ret, pushq): dstE = 4 (%rsp)
  - icode 11 (popq): dstE = 4, dstM = rA
  - icode 5 (mrmovq): dstM = rA
  - all other icodes: both 15
  - A dst ≥ NREG is treated as 15.
- Commit at the rising edge: R[dstE] ← valE, then R[dstM] ← valM. When dstE == dstM, valM wins (popq %rsp leaves %rsp = valM).
- Non-AOK: a valid instruction with w_stat ≠ AOK sets halted and commits nothing. While halted, all writes and counting are suppressed until reset.
- retired increments by 1 per committed valid AOK instruction, including instructions with no destination (e.g. nop, rmmovq, jXX). It wraps modulo 2^CNT_W.
- Reads: rdX = R[srcX]. With BYPASS=1, precedence is: srcX==dstM_o → w_valM; else srcX==dstE_o → w_valE; else array value.

## Timing
- Reset (async assert, synchronous release at clk edge): all R[i]=0, halted=0, retired=0. Read outputs show 0 immediately.
- Write latency is 1 cycle: the array is visible via a non-bypassed read in the cycle after commit. With BYPASS=1, the value is visible in the same cycle, combinationally.
- dstE_o/dstM_o are purely combinational from the current inputs.
- If rst_n is asserted in the same cycle as a write, reset wins and nothing is committed.
- If w_valid=0, the state holds and the outputs depend only on the array and srcA/srcB.

## Test plan
- Reset, then irmovq (icode 3, rB=2, valE=57) → next cycle R[2]=57, retired=1, with all other registers 0.
- cmovXX with rB=10, valE=51: cnd=0 → R[10] unchanged and retired increments; cnd=1 → R[10]=51.
- popq with rA=3, valE=50, valM=40 → R[4]=50, R[3]=40. Then popq with rA=4, valE=50, valM=40 → R[4]=40.
- BYPASS=1, mrmovq with rA=9, valM=49, srcA=9 in the same cycle → rdA=49 before the edge. BYPASS=0 → rdA=old R[9] until the edge.
- Valid instruction with w_stat=HLT → halted=1 with no write. A following irmovq (rB=1, valE=7) leaves R[1]=0 and retired unchanged. rst_n low mid-sequence clears halted, retired and all registers.
- CNT_W=4: commit 16 nops → retired wraps to 0. A register index ≥ NREG on dst or src → no write, and the read returns 0.
